// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch stage.
package mips_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc, instr} pairs with flush.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam logic [AW-1:0] PTR_MASK = '1;

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= (wr_ptr_q + 1'b1) & PTR_MASK;
      end
      if (do_pop) rd_ptr_q <= (rd_ptr_q + 1'b1) & PTR_MASK;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC tracking, single-outstanding memory requests,
// prefetch buffering and redirect flush with late-data discard.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          out_q, out_d;
  logic          pop, push, issue, ack_acc;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count, occ;
  logic [63:0]   fifo_rdata;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (redirect),
    .wdata_i ({mem_addr, mem_rdata}),
    .rdata_o (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign instr_valid       = ~fifo_empty;
  assign {instr_pc, instr} = fifo_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      out_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      out_q      <= out_d;
    end
  end

  always_comb begin
    pop   = instr_valid & instr_ready & ~redirect;
    occ   = fifo_count - CW'(pop);
    // rst gates issue so the request line drops the instant reset asserts.
    issue = ~rst & ~out_q & ~redirect & (occ < CW'(FIFO_DEPTH));
    mem_req  = out_q | issue;
    // The pending request keeps its own address; fetch_pc may be retargeted under it.
    mem_addr = out_q ? req_addr_q : fetch_pc_q;
    ack_acc  = mem_req & mem_ack;

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = mem_addr;
    out_d      = mem_req & ~mem_ack;
    push       = 1'b0;

    case (state_q)
      RUN: begin
        if (redirect) begin
          fetch_pc_d = align_pc(redirect_pc);
          if (out_q & ~mem_ack) state_d = DISCARD;
        end else if (ack_acc) begin
          push       = ~fifo_full | pop;
          fetch_pc_d = fetch_pc_q + PC_INCR;
        end
      end
      DISCARD: begin
        if (mem_ack)  state_d    = RUN;
        if (redirect) fetch_pc_d = align_pc(redirect_pc);
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed checks of fetch_unit against a queue-based stream model.
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_rdata;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  int checks = 0, passes = 0, pop_cnt = 0, saved;

  // model state: buffered PCs, next fetch address, pending request, stale flag
  logic [31:0] q[$];
  logic [31:0] m_fetch = RPC, m_held = RPC;
  bit          m_pending = 0, m_stale = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  task automatic step(input bit ack, input bit rdy, input bit rd, input logic [31:0] rpc);
    bit pop, exp_req, req_m, acc;
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = ack; instr_ready = rdy; redirect = rd; redirect_pc = rpc;
    @(negedge clk);
    chk("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
    chk("fifo_count", 32'(dut.u_fifo.count), q.size());
    chk("valid", {31'd0, instr_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("instr_pc", instr_pc, q[0]);
      chk("instr", instr, mem_word(q[0]));
    end
    pop = (q.size() != 0) && rdy && !rd;
    if (m_pending) begin
      chk("req_hold", {31'd0, mem_req}, 32'd1);
      chk("addr_hold", mem_addr, m_held);
      req_m = 1;
    end else begin
      exp_req = !rd && ((q.size() - int'(pop)) < DEPTH);
      chk("req_issue", {31'd0, mem_req}, {31'd0, exp_req});
      if (exp_req) begin
        m_held = m_fetch;
        chk("req_addr", mem_addr, m_fetch);
      end
      req_m = exp_req;
    end
    acc = req_m && ack;
    if (acc && !rd && !m_stale)
      chk("no_push_full", {31'd0, dut.u_fifo.full && !pop}, 32'd0);
    if (pop) begin
      void'(q.pop_front());
      pop_cnt++;
    end
    if (rd) begin
      q.delete();
      m_fetch = {rpc[31:2], 2'b00};
      if (req_m && !ack) m_stale = 1;
      else if (acc) m_stale = 0;
    end else if (acc) begin
      if (m_stale) m_stale = 0;
      else begin
        q.push_back(m_held);
        m_fetch = m_held + 32'd4;
      end
    end
    m_pending = req_m && !ack;
  endtask

  task automatic apply_reset(input bit stale_ack);
    #2;
    rst = 1'b1; mem_ack = stale_ack; redirect = 1'b0;
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, RPC);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    repeat (2) @(posedge clk);
    q.delete();
    m_fetch = RPC; m_held = RPC; m_pending = 0; m_stale = 0;
  endtask

  initial begin
    apply_reset(1'b0);

    // zero-wait streaming and throughput
    step(1, 1, 0, 0);
    chk("first_req", {31'd0, mem_req}, 32'd1);
    repeat (5) step(1, 1, 0, 0);
    saved = pop_cnt;
    repeat (10) step(1, 1, 0, 0);
    chk("throughput", pop_cnt - saved, 32'd10);

    // backpressure
    repeat (10) step(1, 0, 0, 0);
    chk("bp_count", 32'(dut.u_fifo.count), DEPTH);
    chk("bp_req", {31'd0, mem_req}, 32'd0);
    repeat (8) step(1, 1, 0, 0);

    // redirect with nothing outstanding
    repeat (4) step(1, 0, 0, 0);
    step(1, 0, 1, 32'h0000_0103);
    step(0, 1, 0, 0);
    chk("redir_addr", mem_addr, 32'h0000_0100);
    chk("redir_flush", {31'd0, instr_valid}, 32'd0);
    step(1, 1, 0, 0);

    // redirect during wait states, retarget inside DISCARD
    step(0, 0, 1, 32'h0000_0008);
    step(0, 0, 0, 0);
    chk("ws_addr", mem_addr, 32'h0000_0008);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0040);
    step(0, 0, 1, 32'h0000_0080);
    chk("discard_state", 32'(dut.state_q), 32'd1);
    chk("discard_addr", mem_addr, 32'h0000_0008);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("retarget_req", {31'd0, mem_req}, 32'd1);
    chk("retarget_addr", mem_addr, 32'h0000_0080);
    chk("retarget_valid", {31'd0, instr_valid}, 32'd0);
    repeat (4) step(1, 1, 0, 0);

    // simultaneous redirect + pop + ack
    step(0, 0, 0, 0);
    step(1, 1, 1, 32'h0000_0200);
    step(0, 1, 0, 0);
    chk("sim_valid", {31'd0, instr_valid}, 32'd0);
    chk("sim_addr", mem_addr, 32'h0000_0200);
    repeat (4) step(1, 1, 0, 0);

    // PC wrap
    step(1, 1, 1, 32'hFFFF_FFFE);
    repeat (6) step(1, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(99) < 50), ($urandom_range(99) < 60),
           ($urandom_range(99) < 3), $urandom);

    // reset mid-request, then resume at RESET_PC
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    apply_reset(1'b1);
    step(1, 1, 0, 0);
    chk("post_rst_addr", mem_addr, RPC);
    repeat (5) step(1, 1, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
